half_duplex_bus_ctrl: RTL and testbench
=======================================

// Module: half_duplex_bus_ctrl
// PURPOSE
//   Transaction sequencer for the 8-bit tri-state I/O stage. Sits directly upstream of it:
//   - drives that stage's output enable and output data;
//   - consumes its registered pin readback.
//   Converts host write/read requests (valid/ready) into timed bus-drive and bus-sample
//   windows, with turnaround cycles on every direction change. Read data is returned on a
//   response handshake.
// PARAMETERS
//   DATA_W        8  bus / data width
//   DRIVE_CYCLES  2  cycles io_oe held high per write (>=1)
//   TURN_CYCLES   1  idle cycles with io_oe=0 inserted on direction change (>=0; 0 = no TURN state)
//   SAMPLE_CYCLES 2  cycles io_oe held low per read before capture (>=2; covers readback latency)
// PORTS
//   clk        in   1       single clock, rising edge
//   reset      in   1       asynchronous, active-low reset (0 = reset)
//   req_valid  in   1       host request valid
//   req_ready  out  1       controller can accept request (high only in IDLE)
//   req_wr     in   1       1 = write, 0 = read; sampled on accept
//   req_wdata  in   DATA_W  write data; sampled on accept
//   rsp_valid  out  1       read data valid
//   rsp_ready  in   1       host accepts read data
//   rsp_rdata  out  DATA_W  read data
//   io_oe      out  1       output enable to tri-state stage
//   io_wdata   out  DATA_W  data to drive on the pins
//   io_rdata   in   DATA_W  registered pin readback from the tri-state stage (1-cycle latency)
//   busy       out  1       high in every state except IDLE
// BEHAVIOUR
//   Reset (async, reset=0). Effect is immediate, mid-transaction included:
//   - io_oe=0, io_wdata=0, rsp_valid=0, rsp_rdata=0;
//   - req_ready=0 while reset is held, 1 in the first cycle after release;
//   - state=IDLE, last_dir=READ.
//   FSM states: IDLE, TURN, DRIVE, SAMPLE, RESP. One down-counter, width $clog2(max cycles)+1.
//   IDLE
//   - req_ready=1; accept when req_valid & req_ready.
//   - On accept, latch req_wr and req_wdata.
//   - If the request direction differs from last_dir and TURN_CYCLES>0, go to TURN.
//   - Otherwise go to DRIVE (write) or SAMPLE (read).
//   TURN
//   - io_oe=0 for exactly TURN_CYCLES cycles, then DRIVE or SAMPLE.
//   DRIVE
//   - io_oe=1 and io_wdata=latched data for exactly DRIVE_CYCLES cycles.
//   - last_dir <= WRITE; then IDLE. No write response.
//   - io_oe is 0 in the cycle after the last DRIVE cycle.
//   SAMPLE
//   - io_oe=0 for exactly SAMPLE_CYCLES cycles.
//   - On the last SAMPLE cycle, register io_rdata into rsp_rdata; last_dir <= READ; go to RESP.
//   RESP
//   - rsp_valid=1; rsp_rdata held stable until rsp_valid & rsp_ready; then IDLE.
//   - req_ready=0 throughout RESP; no new request is accepted while a response is pending.
//   io_wdata: holds the last driven value when io_oe=0; it is updated only on accept.
//   io_oe is never 1 outside DRIVE. The controller and the external device never drive the
//   bus together.
//   Latency, request accepted at edge T, no turnaround:
//   - write: io_oe=1 on cycles T+1..T+DRIVE_CYCLES;
//   - read: rsp_valid first high at T+SAMPLE_CYCLES+1.
//   - A required turnaround adds TURN_CYCLES to either latency.
//   Back-to-back requests in the same direction get no turnaround. IDLE lasts a minimum of 1
//   cycle between transactions.
//   If rsp_ready is already high when rsp_valid rises, the response completes in 1 cycle.
// TESTING
//   1. Reset, then write 0xA5 (first op, last_dir=READ):
//      -> 1 TURN cycle with io_oe=0, then io_oe=1 with io_wdata=0xA5 for 2 cycles, busy low after.
//   2. Two consecutive writes 0x11, 0x22:
//      -> no TURN between them; each drives for exactly 2 cycles; req_ready high only in IDLE.
//   3. Write 0x3C then read, with the bench driving io_rdata=0x5A in the sample window
//      -> 1 TURN cycle, 2 SAMPLE cycles with io_oe=0, then rsp_valid=1 with rsp_rdata=0x5A.
//   4. Read with rsp_ready held low for 5 cycles:
//      -> rsp_valid and rsp_rdata stable for all 5 cycles; req_valid is ignored (req_ready=0);
//         completes on the rsp_ready cycle.
//   5. Assert reset (0) during the 2nd DRIVE cycle:
//      -> io_oe=0 immediately (same cycle, asynchronously).
//      -> After release: IDLE, busy=0, and the next write inserts TURN.
//   6. Run with TURN_CYCLES=0, alternating write/read:
//      -> no TURN state visited; read latency is exactly SAMPLE_CYCLES+1.

Source files
------------

// File: rtl/half_duplex_bus_ctrl_if.sv
// half_duplex_bus_ctrl_if: host request/response handshake plus tri-state stage drive/readback
interface half_duplex_bus_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              io_oe;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_wdata, rsp_ready, io_rdata,
        input  req_ready, rsp_valid, rsp_rdata, io_oe, io_wdata, busy
    );

    modport slave (
        input  req_valid, req_wr, req_wdata, rsp_ready, io_rdata,
        output req_ready, rsp_valid, rsp_rdata, io_oe, io_wdata, busy
    );
endinterface

// File: rtl/half_duplex_bus_ctrl.sv
// half_duplex_bus_ctrl: turns host requests into timed drive/sample windows with bus turnaround
module half_duplex_bus_ctrl #(
    parameter int DATA_W        = 8,
    parameter int DRIVE_CYCLES  = 2,
    parameter int TURN_CYCLES   = 1,
    parameter int SAMPLE_CYCLES = 2
) (
    input logic                   clk,
    input logic                   reset,
    half_duplex_bus_ctrl_if.slave bus
);
    localparam int MAX_CYC = DRIVE_CYCLES > SAMPLE_CYCLES
        ? (DRIVE_CYCLES > TURN_CYCLES ? DRIVE_CYCLES : TURN_CYCLES)
        : (SAMPLE_CYCLES > TURN_CYCLES ? SAMPLE_CYCLES : TURN_CYCLES);
    localparam int CW = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);
    localparam logic [CW-1:0] DRIVE_LD  = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TURN, DRIVE, SAMPLE, RESP} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              last_wr, wr_q, accept, last;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    assign accept        = bus.req_valid && bus.req_ready;
    assign last          = cnt == '0;
    // ready is gated by reset so nothing is accepted while reset is held
    assign bus.req_ready = state == IDLE && reset;
    assign bus.busy      = state != IDLE;
    assign bus.io_oe     = state == DRIVE;
    assign bus.rsp_valid = state == RESP;
    assign bus.io_wdata  = wdata_q;
    assign bus.rsp_rdata = rdata_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - 1'b1;
        unique case (state)
            IDLE: if (accept) begin
                state_nx = (bus.req_wr != last_wr && TURN_CYCLES > 0) ? TURN
                         : bus.req_wr ? DRIVE : SAMPLE;
                cnt_nx   = (bus.req_wr != last_wr && TURN_CYCLES > 0) ? TURN_LD
                         : bus.req_wr ? DRIVE_LD : SAMPLE_LD;
            end
            TURN: if (last) begin
                state_nx = wr_q ? DRIVE : SAMPLE;
                cnt_nx   = wr_q ? DRIVE_LD : SAMPLE_LD;
            end
            DRIVE:   state_nx = last ? IDLE : DRIVE;
            SAMPLE:  state_nx = last ? RESP : SAMPLE;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_wr <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) wr_q <= bus.req_wr;
            if (accept && bus.req_wr) wdata_q <= bus.req_wdata;
            if (state == DRIVE && last) last_wr <= 1'b1;
            if (state == SAMPLE && last) begin
                last_wr <= 1'b0;
                rdata_q <= bus.io_rdata;
            end
        end
    end
endmodule

// File: tb/tb_half_duplex_bus_ctrl.sv
// tb_half_duplex_bus_ctrl: directed tests against a per-cycle expected-timeline model, two turnaround settings
module tb_half_duplex_bus_ctrl;
    localparam int DRIVE  = 2;
    localparam int SAMPLE = 2;
    localparam int TURN0  = 1;
    localparam int TURN1  = 0;

    typedef struct packed {
        int         plen;
        logic [3:0] poe;
        logic       pread;
        logic       pend;
        logic       mdir;
        logic [7:0] mw;
        logic [7:0] mr;
    } mdl_t;
    typedef mdl_t [1:0] mdl2_t;

    logic clk, reset;
    logic rv[2], rw[2], rr[2];
    logic [7:0] wd[2], rd_in[2];
    logic rdy[2], rspv[2], oe[2], bsy[2];
    logic [7:0] rdat[2], iow[2];
    mdl2_t m;
    int n_cmp = 0, n_bad = 0;

    half_duplex_bus_ctrl_if #(.DATA_W(8)) bus0 ();
    half_duplex_bus_ctrl_if #(.DATA_W(8)) bus1 ();

    half_duplex_bus_ctrl #(.DATA_W(8), .DRIVE_CYCLES(DRIVE), .TURN_CYCLES(TURN0), .SAMPLE_CYCLES(SAMPLE))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    half_duplex_bus_ctrl #(.DATA_W(8), .DRIVE_CYCLES(DRIVE), .TURN_CYCLES(TURN1), .SAMPLE_CYCLES(SAMPLE))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus0.req_valid = rv[0];
    assign bus0.req_wr    = rw[0];
    assign bus0.req_wdata = wd[0];
    assign bus0.rsp_ready = rr[0];
    assign bus0.io_rdata  = rd_in[0];
    assign rdy[0]  = bus0.req_ready;
    assign rspv[0] = bus0.rsp_valid;
    assign rdat[0] = bus0.rsp_rdata;
    assign oe[0]   = bus0.io_oe;
    assign iow[0]  = bus0.io_wdata;
    assign bsy[0]  = bus0.busy;
    assign bus1.req_valid = rv[1];
    assign bus1.req_wr    = rw[1];
    assign bus1.req_wdata = wd[1];
    assign bus1.rsp_ready = rr[1];
    assign bus1.io_rdata  = rd_in[1];
    assign rdy[1]  = bus1.req_ready;
    assign rspv[1] = bus1.rsp_valid;
    assign rdat[1] = bus1.rsp_rdata;
    assign oe[1]   = bus1.io_oe;
    assign iow[1]  = bus1.io_wdata;
    assign bsy[1]  = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: on accept, lay out the expected io_oe timeline (turnaround zeros, then drive ones or sample zeros)
    function automatic mdl2_t step(mdl2_t c);
        mdl2_t n = c;
        for (int g = 0; g < 2; g++) begin
            int t;
            t = 0;
            if (c[g].plen > 0) begin
                n[g].plen = c[g].plen - 1;
                n[g].poe  = c[g].poe >> 1;
                if (c[g].plen == 1 && c[g].pread) begin
                    n[g].mr   = rd_in[g];
                    n[g].pend = 1'b1;
                end
            end else if (c[g].pend) begin
                if (rr[g]) n[g].pend = 1'b0;
            end else if (rv[g]) begin
                t = (rw[g] != c[g].mdir) ? (g == 0 ? TURN0 : TURN1) : 0;
                n[g].plen  = t + (rw[g] ? DRIVE : SAMPLE);
                n[g].poe   = rw[g] ? 4'(((1 << DRIVE) - 1) << t) : 4'd0;
                n[g].pread = !rw[g];
                n[g].mdir  = rw[g];
                if (rw[g]) n[g].mw = wd[g];
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else m <= step(m);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            logic busy_e;
            busy_e = m[g].plen > 0 || m[g].pend;
            chk($sformatf("busy%0d", g), bsy[g], busy_e);
            chk($sformatf("ready%0d", g), rdy[g], !busy_e);
            chk($sformatf("oe%0d", g), oe[g], m[g].plen > 0 && m[g].poe[0]);
            chk($sformatf("rsp_valid%0d", g), rspv[g], m[g].plen == 0 && m[g].pend);
            chk($sformatf("io_wdata%0d", g), iow[g], m[g].mw);
            chk($sformatf("rsp_rdata%0d", g), rdat[g], m[g].mr);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic request(int g, logic wr, logic [7:0] data);
        logic acc;
        acc = 1'b0;
        rv[g] = 1'b1;
        rw[g] = wr;
        wd[g] = data;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = rdy[g];
            tick();
        end
        rv[g] = 1'b0;
        chk($sformatf("accept%0d", g), acc, 1'b1);
    endtask

    task automatic wait_idle(int g);
        for (int k = 0; k < 50 && bsy[g]; k++) tick();
        chk($sformatf("idle%0d", g), bsy[g], 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            rv[g] = 0; rw[g] = 0; rr[g] = 0; wd[g] = 0; rd_in[g] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready", rdy[0], 1'b0);
        chk("rst_oe", oe[0], 1'b0);
        chk("rst_rsp_valid", rspv[0], 1'b0);
        chk("rst_wdata", iow[0], 8'h00);
        reset = 1'b1;
        #1;
        chk("rel_ready", rdy[0], 1'b1);
        chk("rel_busy", bsy[0], 1'b0);
        // 1: first write after reset needs a turnaround
        request(0, 1'b1, 8'hA5);
        chk("t1_turn_oe", oe[0], 1'b0);
        chk("t1_turn_busy", bsy[0], 1'b1);
        tick();
        chk("t1_d1_oe", oe[0], 1'b1);
        chk("t1_d1_wdata", iow[0], 8'hA5);
        tick();
        chk("t1_d2_oe", oe[0], 1'b1);
        tick();
        chk("t1_end_oe", oe[0], 1'b0);
        chk("t1_end_busy", bsy[0], 1'b0);
        chk("t1_hold_wdata", iow[0], 8'hA5);
        // 2: same-direction writes, no turnaround
        request(0, 1'b1, 8'h11);
        chk("t2_a_oe", oe[0], 1'b1);
        chk("t2_a_wdata", iow[0], 8'h11);
        tick();
        chk("t2_a2_oe", oe[0], 1'b1);
        tick();
        chk("t2_gap_oe", oe[0], 1'b0);
        chk("t2_gap_ready", rdy[0], 1'b1);
        request(0, 1'b1, 8'h22);
        chk("t2_b_oe", oe[0], 1'b1);
        chk("t2_b_wdata", iow[0], 8'h22);
        wait_idle(0);
        // 3: write then read with turnaround
        request(0, 1'b1, 8'h3C);
        wait_idle(0);
        rd_in[0] = 8'h5A;
        request(0, 1'b0, 8'h00);
        chk("t3_turn_oe", oe[0], 1'b0);
        chk("t3_turn_rv", rspv[0], 1'b0);
        tick();
        chk("t3_s1_oe", oe[0], 1'b0);
        chk("t3_s1_rv", rspv[0], 1'b0);
        tick();
        chk("t3_s2_rv", rspv[0], 1'b0);
        tick();
        chk("t3_rv", rspv[0], 1'b1);
        chk("t3_rdata", rdat[0], 8'h5A);
        chk("t3_wdata_kept", iow[0], 8'h3C);
        rr[0] = 1'b1;
        tick();
        rr[0] = 1'b0;
        chk("t3_done", bsy[0], 1'b0);
        // 4: read with stalled response, readback changing every cycle
        request(0, 1'b0, 8'h00);
        rd_in[0] = 8'hC0;
        tick();
        rd_in[0] = 8'hC1;
        tick();
        rd_in[0] = 8'hC2;
        rv[0] = 1'b1;
        rw[0] = 1'b1;
        wd[0] = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            chk("t4_rv", rspv[0], 1'b1);
            chk("t4_rdata", rdat[0], 8'hC1);
            chk("t4_ready", rdy[0], 1'b0);
            rd_in[0] = 8'(8'h90 + k);
            tick();
        end
        rv[0] = 1'b0;
        rr[0] = 1'b1;
        tick();
        rr[0] = 1'b0;
        chk("t4_done", bsy[0], 1'b0);
        // 5: reset during the second drive cycle
        request(0, 1'b1, 8'h77);
        tick();
        chk("t5_d1_oe", oe[0], 1'b1);
        tick();
        chk("t5_d2_oe", oe[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_oe", oe[0], 1'b0);
        chk("t5_async_busy", bsy[0], 1'b0);
        chk("t5_async_ready", rdy[0], 1'b0);
        chk("t5_async_wdata", iow[0], 8'h00);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_rel_ready", rdy[0], 1'b1);
        request(0, 1'b1, 8'h88);
        chk("t5_turn_oe", oe[0], 1'b0);
        chk("t5_turn_busy", bsy[0], 1'b1);
        wait_idle(0);
        // 6: no turnaround configured, alternating directions
        request(1, 1'b1, 8'h12);
        chk("t6_w_oe", oe[1], 1'b1);
        chk("t6_w_wdata", iow[1], 8'h12);
        tick();
        chk("t6_w2_oe", oe[1], 1'b1);
        tick();
        chk("t6_w_end", bsy[1], 1'b0);
        rd_in[1] = 8'h34;
        rr[1] = 1'b1;
        request(1, 1'b0, 8'h00);
        chk("t6_r1_rv", rspv[1], 1'b0);
        chk("t6_r1_oe", oe[1], 1'b0);
        tick();
        chk("t6_r2_rv", rspv[1], 1'b0);
        tick();
        chk("t6_r3_rv", rspv[1], 1'b1);
        chk("t6_rdata", rdat[1], 8'h34);
        tick();
        chk("t6_r_done", bsy[1], 1'b0);
        rr[1] = 1'b0;
        request(1, 1'b1, 8'h56);
        chk("t6_w3_oe", oe[1], 1'b1);
        wait_idle(1);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
